// File: rtl/alu_muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and operand signedness helpers.
package muldiv_pkg;

    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_MULHU  = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_DIVU   = 3'b101;
    localparam logic [2:0] OP_REM    = 3'b110;
    localparam logic [2:0] OP_REMU   = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    function automatic logic is_signed_a(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_signed_b(input logic [2:0] op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

endpackage

// File: rtl/alu_muldiv_if.sv
// Issue/result handshake bundle between the execute stage (master) and the
// multiply/divide unit (slave).
interface alu_muldiv_if #(
    parameter int W_SIZE = 32
);
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        op;
    logic [W_SIZE-1:0] a;
    logic [W_SIZE-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [W_SIZE-1:0] result;

    modport master (
        output flush, in_valid, op, a, b, out_ready,
        input  in_ready, out_valid, result
    );

    modport slave (
        input  flush, in_valid, op, a, b, out_ready,
        output in_ready, out_valid, result
    );
endinterface

// File: rtl/alu_muldiv_negate.sv
// Conditional two's-complement: out = neg_en ? -in : in.
module muldiv_negate #(
    parameter int WIDTH = 32
) (
    input  logic             neg_en,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out
);
    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    assign out = neg_en ? (~in + ONE) : in;
endmodule

// File: rtl/alu_muldiv.sv
// Iterative RV32M multiply/divide: W_SIZE-cycle shift-add multiplier and restoring
// divider on magnitudes, sign fix-up in FIX. Optional macro: ALU_MULDIV_EARLY_OUT_EN.
import muldiv_pkg::*;

module alu_muldiv #(
    parameter int W_SIZE = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    alu_muldiv_if.slave    bus
);
    localparam int              CW       = $clog2(W_SIZE) + 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(W_SIZE);
    localparam logic [CW-1:0]   CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [W_SIZE-1:0] MIN_VAL = {1'b1, {(W_SIZE-1){1'b0}}};

    state_t                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  sign_a_q, sign_a_d;
    logic                  sign_b_q, sign_b_d;
    logic                  div_zero_q, div_zero_d;
    logic                  ovf_q, ovf_d;
    logic [W_SIZE-1:0]     a_q, a_d;
    logic [W_SIZE-1:0]     mag_b_q, mag_b_d;
    logic [2*W_SIZE-1:0]   prod_q, prod_d;
    logic [W_SIZE-1:0]     quo_q, quo_d;
    logic [W_SIZE:0]       rem_q, rem_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic                  out_valid_q, out_valid_d;
    logic [W_SIZE-1:0]     result_q, result_d;

    // Operand capture: signedness and magnitudes of the offered operands
    logic                  sa_in, sb_in, b_zero_in, ovf_in, accept;
    logic [W_SIZE-1:0]     mag_a_in, mag_b_in;

    assign sa_in     = is_signed_a(bus.op) & bus.a[W_SIZE-1];
    assign sb_in     = is_signed_b(bus.op) & bus.b[W_SIZE-1];
    assign b_zero_in = (bus.b == '0);
    assign ovf_in    = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                       (bus.a == MIN_VAL) && (bus.b == '1);
    assign accept    = bus.in_valid & (state_q == S_IDLE) & ~bus.flush;

    muldiv_negate #(.WIDTH(W_SIZE)) u_neg_a (.neg_en(sa_in), .in(bus.a), .out(mag_a_in));
    muldiv_negate #(.WIDTH(W_SIZE)) u_neg_b (.neg_en(sb_in), .in(bus.b), .out(mag_b_in));

`ifdef ALU_MULDIV_EARLY_OUT_EN
    logic early_in;
    assign early_in = bus.op[2] ? (b_zero_in | ovf_in) : ((bus.a == '0) || (bus.b == '0));
`endif

    // One shift-add step on the product register
    logic [W_SIZE:0]       mul_acc;
    logic [2*W_SIZE-1:0]   mul_next;
    assign mul_acc  = {1'b0, prod_q[2*W_SIZE-1:W_SIZE]} + (prod_q[0] ? {1'b0, mag_b_q} : '0);
    assign mul_next = {mul_acc, prod_q[W_SIZE-1:1]};

    // One restoring-division step; the partial remainder's top bit forces a subtract
    logic [W_SIZE:0]       div_shift, div_diff;
    logic                  div_ge;
    assign div_shift = {rem_q[W_SIZE-1:0], quo_q[W_SIZE-1]};
    assign div_ge    = rem_q[W_SIZE] | (div_shift >= {1'b0, mag_b_q});
    assign div_diff  = div_shift - {1'b0, mag_b_q};

    // Sign fix-up: the full double-width product is negated so MULH* high words are exact
    logic                  is_mul, fix_neg;
    logic [2*W_SIZE-1:0]   fix_in, fix_out;
    logic [W_SIZE-1:0]     fix_result;

    assign is_mul  = ~op_q[2];
    assign fix_in  = is_mul ? prod_q
                            : {{W_SIZE{1'b0}}, (op_q[1] ? rem_q[W_SIZE-1:0] : quo_q)};
    assign fix_neg = (is_mul || !op_q[1]) ? (sign_a_q ^ sign_b_q) : sign_a_q;

    muldiv_negate #(.WIDTH(2*W_SIZE)) u_neg_fix (.neg_en(fix_neg), .in(fix_in), .out(fix_out));

    always_comb begin
        fix_result = fix_out[W_SIZE-1:0];
        if (is_mul) begin
            if (op_q != OP_MUL) fix_result = fix_out[2*W_SIZE-1:W_SIZE];
        end else if (div_zero_q) begin
            fix_result = op_q[1] ? a_q : '1;
        end else if (ovf_q) begin
            fix_result = op_q[1] ? '0 : a_q;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        sign_a_d    = sign_a_q;
        sign_b_d    = sign_b_q;
        div_zero_d  = div_zero_q;
        ovf_d       = ovf_q;
        a_d         = a_q;
        mag_b_d     = mag_b_q;
        prod_d      = prod_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    op_d       = bus.op;
                    sign_a_d   = sa_in;
                    sign_b_d   = sb_in;
                    div_zero_d = b_zero_in;
                    ovf_d      = ovf_in;
                    a_d        = bus.a;
                    mag_b_d    = mag_b_in;
                    quo_d      = mag_a_in;
                    rem_d      = '0;
                    cnt_d      = '0;
`ifdef ALU_MULDIV_EARLY_OUT_EN
                    // Trivial cases skip the iteration and resolve in FIX
                    state_d    = early_in ? S_FIX : S_CALC;
                    prod_d     = early_in ? '0 : {{W_SIZE{1'b0}}, mag_a_in};
`else
                    state_d    = S_CALC;
                    prod_d     = {{W_SIZE{1'b0}}, mag_a_in};
`endif
                end
            end
            S_CALC: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    if (is_mul) begin
                        prod_d = mul_next;
                    end else begin
                        rem_d = div_ge ? div_diff : div_shift;
                        quo_d = {quo_q[W_SIZE-2:0], div_ge};
                    end
                end
            end
            S_FIX: begin
                result_d    = fix_result;
                out_valid_d = 1'b1;
                state_d     = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (bus.flush) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            result_d    = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= '0;
            sign_a_q    <= 1'b0;
            sign_b_q    <= 1'b0;
            div_zero_q  <= 1'b0;
            ovf_q       <= 1'b0;
            a_q         <= '0;
            mag_b_q     <= '0;
            prod_q      <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            sign_a_q    <= sign_a_d;
            sign_b_q    <= sign_b_d;
            div_zero_q  <= div_zero_d;
            ovf_q       <= ovf_d;
            a_q         <= a_d;
            mag_b_q     <= mag_b_d;
            prod_q      <= prod_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;

endmodule

// File: tb/tb_alu_muldiv.sv
// Directed bench for alu_muldiv (W_SIZE=32): arithmetic model, per-cycle result
// compare, latency, backpressure, flush and asynchronous reset.
module tb_alu_muldiv;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    logic pending;
    logic [W-1:0] exp_q;

    alu_muldiv_if #(.W_SIZE(W)) bus ();

    alu_muldiv #(.W_SIZE(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference semantics straight from the RV32M definitions
    function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
        longint          sa, sb;
        longint unsigned ua, ub;
        logic [63:0]     p;
        logic [W-1:0]    r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        r  = '0;
        case (op)
            3'd0: begin p = ua * ub;          r = p[31:0];  end
            3'd1: begin p = sa * sb;          r = p[63:32]; end
            3'd2: begin p = sa * longint'(ub); r = p[63:32]; end
            3'd3: begin p = ua * ub;          r = p[63:32]; end
            3'd4: if (b == 0) r = '1; else if (a == 32'h8000_0000 && b == '1) r = a;
                  else begin p = sa / sb; r = p[31:0]; end
            3'd5: if (b == 0) r = '1; else begin p = ua / ub; r = p[31:0]; end
            3'd6: if (b == 0) r = a; else if (a == 32'h8000_0000 && b == '1) r = '0;
                  else begin p = sa % sb; r = p[31:0]; end
            default: if (b == 0) r = a; else begin p = ua % ub; r = p[31:0]; end
        endcase
        return r;
    endfunction

    function automatic logic is_trivial(input logic [2:0] op, input logic [W-1:0] a,
                                        input logic [W-1:0] b);
        if (op[2]) return (b == 0) || ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == '1);
        return (a == 0) || (b == 0);
    endfunction

    // Every cycle a result is presented it must be the expected one and the unit busy
    always @(negedge clk) begin
        if (rst_n && bus.out_valid) begin
            check("cmp_pending", {31'b0, pending}, 32'd1);
            check("cmp_result", bus.result, exp_q);
            check("cmp_in_ready", {31'b0, bus.in_ready}, 32'd0);
        end
    end

    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] exp_lit, input int hold);
        int lat;
        int exp_lat;
        check("model_pin", model(op, a, b), exp_lit);
        exp_lat = 34;
`ifdef ALU_MULDIV_EARLY_OUT_EN
        if (is_trivial(op, a, b)) exp_lat = 1;
`endif
        @(negedge clk);
        check("in_ready_idle", {31'b0, bus.in_ready}, 32'd1);
        exp_q        = model(op, a, b);
        pending      = 1'b1;
        bus.in_valid = 1'b1;
        bus.op       = op;
        bus.a        = a;
        bus.b        = b;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        check("in_ready_busy", {31'b0, bus.in_ready}, 32'd0);
        lat = 0;
        while (!bus.out_valid && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        repeat (hold) @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        pending       = 1'b0;
        check("out_valid_after_hs", {31'b0, bus.out_valid}, 32'd0);
        check("in_ready_after_hs", {31'b0, bus.in_ready}, 32'd1);
        $display("[TB] op=%0d a=%h b=%h result=%h expected=%h latency=%0d hold=%0d",
                 op, a, b, bus.result, exp_lit, lat, hold);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp;
        int           hold;
    } vec_t;

    vec_t vecs[$] = '{
        '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 0},
        '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 0},
        '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 0},
        '{3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 0},
        '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 0},
        '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 0},
        '{3'd5, 32'd100,        32'd7,         32'd14,        0},
        '{3'd7, 32'd100,        32'd7,         32'd2,         5},
        '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 0},
        '{3'd6, 32'd5,          32'd0,         32'd5,         0},
        '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 0},
        '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         0},
        '{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0},
        '{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1,         0},
        '{3'd3, 32'h1234_5678,  32'h10,        32'd1,         0},
        '{3'd0, 32'd0,          32'd5,         32'd0,         0},
        '{3'd7, 32'd7,          32'd0,         32'd7,         0}
    };

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        pending       = 1'b0;
        exp_q         = '0;
        rst_n         = 1'b0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = '0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        #1;
        check("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("reset_result", bus.result, 32'd0);
        check("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].hold);

        // Flush ten cycles into CALC: the result must never appear
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'd0; bus.a = 32'd9; bus.b = 32'd9;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus.flush = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        check("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
        // Flush together with an offered op: the op is not taken
        @(negedge clk);
        bus.flush = 1'b1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.flush = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_same_cycle_in_ready", {31'b0, bus.in_ready}, 32'd1);
        repeat (40) @(posedge clk);
        #1;
        check("flush_no_result", {31'b0, bus.out_valid}, 32'd0);
        $display("[TB] flush sequence done in_ready=%0d out_valid=%0d", bus.in_ready, bus.out_valid);

        // Asynchronous reset mid-CALC (last result register holds a nonzero value)
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op = 3'd5; bus.a = 32'd100; bus.b = 32'd7;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", {31'b0, bus.out_valid}, 32'd0);
        check("rst_mid_result", bus.result, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rst_release_in_ready", {31'b0, bus.in_ready}, 32'd1);
        $display("[TB] reset mid-CALC done result=%h", bus.result);
        run_op(3'd0, 32'd3, 32'd4, 32'd12, 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
